fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 clk  input  1  clock; all state updates on rising edge.
REQ-002 rst  input  1  reset, synchronous, active-high.
REQ-003 pc  input  32  current fetch address from the PC unit.
REQ-004 pc_en  output  1  one-cycle pulse telling the PC unit to advance to its next value.
REQ-005 flush  input  1  branch redirect; kills in-flight and buffered fetches.
REQ-006 imem_req_valid  output  1  instruction-memory request valid.
REQ-007 imem_req_addr  output  32  request word address.
REQ-008 imem_req_ready  input  1  memory accepts the request this cycle.
REQ-009 imem_rsp_valid  input  1  read data valid.
REQ-010 imem_rsp_data  input  32  instruction word.
REQ-011 id_ready  input  1  decode stage accepts the IF/ID register this cycle.
REQ-012 id_valid  output  1  IF/ID register holds a valid entry.
REQ-013 id_pc  output  32  PC of the held instruction.
REQ-014 id_pc_plus4  output  32  id_pc + 4.
REQ-015 id_instr  output  32  held instruction word.
REQ-016 id_misalign  output  1  held entry is a misaligned-fetch fault.

Function
REQ-017 The FSM SHALL have states IDLE, REQ, WAIT and DROP, with at most one outstanding memory request.
REQ-018 IDLE SHALL last exactly one cycle after reset deassertion, then go to REQ.
REQ-019 The block SHALL drive imem_req_valid=1 in REQ only when flush=0, pc[1:0]==0 and (id_valid==0 or id_ready==1).
REQ-020 imem_req_addr SHALL equal pc and SHALL hold stable while imem_req_valid=1 and imem_req_ready=0.
REQ-021 On request acceptance (valid & ready), pc_en SHALL pulse for that cycle and the FSM SHALL go to WAIT; pc_en SHALL be 0 at all other times.
REQ-022 In WAIT with imem_rsp_valid=1 and flush=0, the IF/ID register SHALL load {pc, pc+4, rsp_data, misalign=0} with id_valid=1 next cycle, and the FSM SHALL go to REQ.
REQ-023 Minimum latency SHALL be: request accepted in cycle N, response in N+1, id_valid=1 in N+2.
REQ-024 A response SHALL always land in an empty IF/ID register, because issue requires that register to be empty or draining.
REQ-025 IF/ID contents SHALL hold unchanged while id_valid=1 and id_ready=0.
REQ-026 id_valid SHALL clear on id_ready=1 unless it is reloaded in the same cycle.
REQ-027 In REQ with pc[1:0]!=0 and the IF/ID register empty or draining, the block SHALL issue no request and SHALL load {pc, pc+4, 0x00000013, misalign=1}.
  - pc_en stays 0; the FSM stays in REQ.
  - Recovery is by flush from downstream.
REQ-028 id_pc_plus4 SHALL be computed modulo 2^32 (0xFFFFFFFC -> 0x00000000).
REQ-029 flush=1 SHALL clear id_valid next cycle, with priority over id_ready and over any load.
REQ-030 flush=1 SHALL force imem_req_valid=0 in that cycle.
REQ-031 flush in WAIT without a same-cycle response SHALL go to DROP.
REQ-032 flush in WAIT coincident with imem_rsp_valid SHALL discard the data and go to REQ.
REQ-033 DROP SHALL discard the next response and then go to REQ; flush while in DROP SHALL keep the FSM in DROP.
REQ-034 imem_rsp_valid SHALL be ignored in IDLE and REQ.

Reset
REQ-035 With rst=1 at a clock edge, the block SHALL enter IDLE and clear all outputs to 0 (pc_en, imem_req_valid, imem_req_addr, id_valid, id_pc, id_pc_plus4, id_instr, id_misalign), regardless of state.
REQ-036 rst SHALL take priority over flush and all handshakes.
REQ-037 Instruction memory SHALL be reset by the same rst, so no response from before reset is delivered.

Verification
REQ-038 Basic fetch: pc=0x100, ready=1, response next cycle with 0x00A00093, id_ready=1 -> pc_en pulses once; two cycles later id_valid=1, id_pc=0x100, id_pc_plus4=0x104, id_instr=0x00A00093.
REQ-039 Backpressure: id_ready=0 with IF/ID full -> no new request, outputs stable for 5 cycles; id_ready=1 -> request issued in that same cycle.
REQ-040 Memory stall: imem_req_ready=0 for 3 cycles at pc=0x200 -> imem_req_valid and addr=0x200 held stable; pc_en pulses only on the accept cycle.
REQ-041 Flush in WAIT: flush one cycle after accept, response two cycles later -> response dropped, id_valid stays 0, next request issued after DROP.
REQ-042 Misaligned and wrap: pc=0x102 -> id_misalign=1, id_instr=0x00000013, no request; pc=0xFFFFFFFC -> id_pc_plus4=0x00000000.
REQ-043 Reset mid-WAIT: rst=1 while WAIT -> next cycle all outputs 0, state IDLE, first request two cycles after rst deasserts.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction fetch stage: issues one instruction-memory request at a time,
// captures the returned word into the IF/ID register and handles redirects.
module fetch_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc,
    output logic        pc_en,
    input  logic        flush,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        id_ready,
    output logic        id_valid,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc_plus4,
    output logic [31:0] id_instr,
    output logic        id_misalign
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} state_t;

    state_t      state_q, state_d;
    logic [31:0] req_pc_q, req_pc_d;     // address of the outstanding request
    logic        id_valid_q, id_valid_d;
    logic [31:0] id_pc_q, id_pc_d;
    logic [31:0] id_pc4_q, id_pc4_d;
    logic [31:0] id_instr_q, id_instr_d;
    logic        id_mis_q, id_mis_d;

    logic        can_take;               // IF/ID is empty or draining this cycle
    logic        load;
    logic [31:0] load_pc;
    logic [31:0] load_instr;
    logic        load_mis;

    assign can_take = !id_valid_q || id_ready;

    // Next-state, request handshake and IF/ID load selection
    always_comb begin
        state_d        = state_q;
        req_pc_d       = req_pc_q;
        pc_en          = 1'b0;
        imem_req_valid = 1'b0;
        imem_req_addr  = 32'h0;
        load           = 1'b0;
        load_pc        = pc;
        load_instr     = NOP;
        load_mis       = 1'b0;

        case (state_q)
            IDLE: state_d = REQ;
            REQ: begin
                if (!flush && can_take) begin
                    if (pc[1:0] == 2'b00) begin
                        imem_req_valid = 1'b1;
                        imem_req_addr  = pc;
                        if (imem_req_ready) begin
                            pc_en    = 1'b1;
                            req_pc_d = pc;
                            state_d  = WAIT;
                        end
                    end else begin
                        // Misaligned PC: hand decode a fault entry, stay put until redirected
                        load     = 1'b1;
                        load_mis = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (flush) begin
                    state_d = imem_rsp_valid ? REQ : DROP;
                end else if (imem_rsp_valid) begin
                    load       = 1'b1;
                    load_pc    = req_pc_q;
                    load_instr = imem_rsp_data;
                    state_d    = REQ;
                end
            end
            // The killed request's response is swallowed whenever it arrives,
            // even alongside another flush, since nothing else is outstanding.
            DROP: if (imem_rsp_valid) state_d = REQ;
            default: state_d = IDLE;
        endcase

        // Reset dominates every handshake, including the combinational ones
        if (rst) begin
            pc_en          = 1'b0;
            imem_req_valid = 1'b0;
            imem_req_addr  = 32'h0;
        end
    end

    // IF/ID register update: flush beats load, load beats drain
    always_comb begin
        id_valid_d = id_valid_q;
        id_pc_d    = id_pc_q;
        id_pc4_d   = id_pc4_q;
        id_instr_d = id_instr_q;
        id_mis_d   = id_mis_q;
        if (flush) begin
            id_valid_d = 1'b0;
        end else if (load) begin
            id_valid_d = 1'b1;
            id_pc_d    = load_pc;
            id_pc4_d   = load_pc + 32'd4;
            id_instr_d = load_instr;
            id_mis_d   = load_mis;
        end else if (id_ready) begin
            id_valid_d = 1'b0;
        end
    end

    // State and IF/ID registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            req_pc_q   <= 32'h0;
            id_valid_q <= 1'b0;
            id_pc_q    <= 32'h0;
            id_pc4_q   <= 32'h0;
            id_instr_q <= 32'h0;
            id_mis_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            req_pc_q   <= req_pc_d;
            id_valid_q <= id_valid_d;
            id_pc_q    <= id_pc_d;
            id_pc4_q   <= id_pc4_d;
            id_instr_q <= id_instr_d;
            id_mis_q   <= id_mis_d;
        end
    end

    assign id_valid    = id_valid_q;
    assign id_pc       = id_pc_q;
    assign id_pc_plus4 = id_pc4_q;
    assign id_instr    = id_instr_q;
    assign id_misalign = id_mis_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: PC unit, instruction memory and decode are modelled
// here; delivered fetches are predicted into a queue and checked by a monitor.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc = 32'h0;
    logic        flush = 1'b0;
    logic        imem_req_ready = 1'b0;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = 32'h0;
    logic        id_ready = 1'b0;
    logic        pc_en, imem_req_valid, id_valid, id_misalign;
    logic [31:0] imem_req_addr, id_pc, id_pc_plus4, id_instr;

    fetch_stage dut (
        .clk(clk), .rst(rst), .pc(pc), .pc_en(pc_en), .flush(flush),
        .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
        .imem_req_ready(imem_req_ready), .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data), .id_ready(id_ready), .id_valid(id_valid),
        .id_pc(id_pc), .id_pc_plus4(id_pc_plus4), .id_instr(id_instr),
        .id_misalign(id_misalign)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] epc;
        logic [31:0] epc4;
        logic [31:0] instr;
        logic        mis;
    } ent_t;

    ent_t        exp_q[$];
    ent_t        mon_e;
    int          checks = 0;
    int          failures = 0;
    int          consumed = 0;
    bit          rand_mode = 1'b0;
    int          mem_delay = 0;
    logic [31:0] redirect_pc = 32'h0;
    bit          outstanding = 1'b0;
    bit          killed = 1'b0;
    bit          real_rsp = 1'b0;
    logic [31:0] rsp_addr = 32'h0;
    int          rsp_cnt = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] h;
        if (a == 32'h0000_0100) return 32'h00A0_0093;
        h = a * 32'h9E37_79B1;
        return h ^ 32'h5A5A_0000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        chk1({tag, "_pc_en"}, pc_en, 1'b0);
        chk1({tag, "_req_valid"}, imem_req_valid, 1'b0);
        chk({tag, "_req_addr"}, imem_req_addr, 32'h0);
        chk1({tag, "_id_valid"}, id_valid, 1'b0);
        chk({tag, "_id_pc"}, id_pc, 32'h0);
        chk({tag, "_id_pc4"}, id_pc_plus4, 32'h0);
        chk({tag, "_id_instr"}, id_instr, 32'h0);
        chk1({tag, "_id_mis"}, id_misalign, 1'b0);
    endtask

    // One clock: observe the cycle at negedge, update PC/memory models,
    // then drive the next cycle's inputs and let them settle.
    task automatic step();
        logic [31:0] npc;
        ent_t        e;
        @(negedge clk);
        chk1("pc_en_iff_accept", pc_en, imem_req_valid && imem_req_ready);
        chk1("no_req_on_flush", imem_req_valid && flush, 1'b0);
        chk1("no_req_when_full", imem_req_valid && id_valid && !id_ready, 1'b0);
        if (imem_req_valid) chk("req_addr_is_pc", imem_req_addr, pc);
        npc = pc;
        if (rst) begin
            outstanding = 1'b0;
            killed = 1'b0;
            exp_q.delete();
        end else begin
            if (pc_en) npc = pc + 32'd4;
            if (flush) begin
                exp_q.delete();
                if (outstanding) killed = 1'b1;
                npc = redirect_pc;
            end
            if (real_rsp) begin
                if (!killed) begin
                    e.epc = rsp_addr;
                    e.epc4 = rsp_addr + 32'd4;
                    e.instr = mem_word(rsp_addr);
                    e.mis = 1'b0;
                    exp_q.push_back(e);
                end
                outstanding = 1'b0;
                killed = 1'b0;
            end
            if (imem_req_valid && imem_req_ready) begin
                outstanding = 1'b1;
                killed = 1'b0;
                rsp_addr = imem_req_addr;
                rsp_cnt = rand_mode ? int'($urandom_range(0, 3)) : mem_delay;
            end
        end
        @(posedge clk);
        #1;
        pc = npc;
        real_rsp = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data = 32'h0;
        if (outstanding) begin
            if (rsp_cnt == 0) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data = mem_word(rsp_addr);
                real_rsp = 1'b1;
            end else begin
                rsp_cnt--;
            end
        end else if (rand_mode && $urandom_range(0, 7) == 0) begin
            imem_rsp_valid = 1'b1;              // stray strobe with nothing outstanding
            imem_rsp_data = $urandom;
        end
        if (rand_mode) begin
            id_ready = ($urandom_range(0, 3) != 0);
            imem_req_ready = ($urandom_range(0, 2) != 0);
            flush = ($urandom_range(0, 15) == 0);
            redirect_pc = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'h0000_FFFC);
        end
        #1;
    endtask

    // Reset for two cycles, check cleared outputs, release into the IDLE cycle
    task automatic do_reset(input logic [31:0] start_pc);
        rand_mode = 1'b0;
        rst = 1'b1;
        flush = 1'b0;
        imem_req_ready = 1'b1;
        id_ready = 1'b1;
        mem_delay = 0;
        pc = start_pc;
        step();
        step();
        check_zero("reset");
        rst = 1'b0;
        #1;
        chk1("idle_no_req", imem_req_valid, 1'b0);
    endtask

    // Monitor: every entry decode takes must be the oldest predicted fetch
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (!rst && id_valid && id_ready && !flush) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_entry: got pc %h expected no entry", id_pc);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("sb_id_pc", id_pc, mon_e.epc);
                    chk("sb_id_pc4", id_pc_plus4, mon_e.epc4);
                    chk("sb_id_instr", id_instr, mon_e.instr);
                    chk1("sb_id_mis", id_misalign, mon_e.mis);
                    consumed++;
                end
            end
        end
    end

    initial begin
        // Basic fetch with minimum latency
        do_reset(32'h100);
        step();
        chk1("a_req_valid", imem_req_valid, 1'b1);
        chk("a_req_addr", imem_req_addr, 32'h100);
        chk1("a_pc_en", pc_en, 1'b1);
        step();
        chk1("a_pc_en_once", pc_en, 1'b0);
        chk1("a_not_yet_valid", id_valid, 1'b0);
        step();
        chk1("a_id_valid", id_valid, 1'b1);
        chk("a_id_pc", id_pc, 32'h100);
        chk("a_id_pc4", id_pc_plus4, 32'h104);
        chk("a_id_instr", id_instr, 32'h00A0_0093);
        repeat (4) step();

        // Backpressure from decode
        do_reset(32'h300);
        id_ready = 1'b0;
        step();
        step();
        step();
        chk1("b_id_valid", id_valid, 1'b1);
        for (int i = 0; i < 5; i++) begin
            chk1("b_no_req", imem_req_valid, 1'b0);
            chk1("b_hold_valid", id_valid, 1'b1);
            chk("b_hold_pc", id_pc, 32'h300);
            chk("b_hold_instr", id_instr, mem_word(32'h300));
            step();
        end
        id_ready = 1'b1;
        #1;
        chk1("b_req_on_ready", imem_req_valid, 1'b1);
        chk("b_req_addr", imem_req_addr, 32'h304);
        step();
        repeat (4) step();

        // Memory stall
        do_reset(32'h200);
        imem_req_ready = 1'b0;
        step();
        for (int i = 0; i < 3; i++) begin
            chk1("c_stall_valid", imem_req_valid, 1'b1);
            chk("c_stall_addr", imem_req_addr, 32'h200);
            chk1("c_stall_pc_en", pc_en, 1'b0);
            step();
        end
        imem_req_ready = 1'b1;
        #1;
        chk1("c_accept_pc_en", pc_en, 1'b1);
        chk("c_accept_addr", imem_req_addr, 32'h200);
        step();
        chk1("c_wait_no_req", imem_req_valid, 1'b0);
        repeat (4) step();

        // Flush while waiting, response lands in DROP
        do_reset(32'h400);
        mem_delay = 2;
        step();
        chk1("d_accept", pc_en, 1'b1);
        step();
        flush = 1'b1;
        redirect_pc = 32'h500;
        #1;
        chk1("d_flush_no_req", imem_req_valid, 1'b0);
        step();
        flush = 1'b0;
        #1;
        chk1("d_drop_no_req", imem_req_valid, 1'b0);
        chk1("d_drop_no_id", id_valid, 1'b0);
        step();
        chk1("d_rsp_dropped_req", imem_req_valid, 1'b0);
        chk1("d_rsp_dropped_id", id_valid, 1'b0);
        step();
        chk1("d_after_drop_req", imem_req_valid, 1'b1);
        chk("d_after_drop_addr", imem_req_addr, 32'h500);
        chk1("d_after_drop_id", id_valid, 1'b0);
        mem_delay = 0;
        repeat (4) step();

        // Misaligned PC, then redirect to the top of the address space
        do_reset(32'h102);
        id_ready = 1'b0;
        step();
        chk1("e_mis_no_req", imem_req_valid, 1'b0);
        chk1("e_mis_no_pc_en", pc_en, 1'b0);
        step();
        chk1("e_mis_valid", id_valid, 1'b1);
        chk1("e_mis_flag", id_misalign, 1'b1);
        chk("e_mis_instr", id_instr, 32'h0000_0013);
        chk("e_mis_pc", id_pc, 32'h102);
        chk("e_mis_pc4", id_pc_plus4, 32'h106);
        chk1("e_mis_still_no_req", imem_req_valid, 1'b0);
        flush = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        step();
        flush = 1'b0;
        id_ready = 1'b1;
        #1;
        chk1("e_flush_clears", id_valid, 1'b0);
        chk1("e_wrap_req", imem_req_valid, 1'b1);
        chk("e_wrap_addr", imem_req_addr, 32'hFFFF_FFFC);
        step();
        step();
        chk1("e_wrap_valid", id_valid, 1'b1);
        chk("e_wrap_pc", id_pc, 32'hFFFF_FFFC);
        chk("e_wrap_pc4", id_pc_plus4, 32'h0000_0000);
        repeat (3) step();

        // Reset in the middle of a wait
        do_reset(32'h600);
        mem_delay = 2;
        step();
        chk1("f_accept", pc_en, 1'b1);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        check_zero("f_after_rst");
        step();
        chk1("f_first_req", imem_req_valid, 1'b1);
        chk("f_first_addr", imem_req_addr, 32'h604);
        mem_delay = 0;
        repeat (6) step();

        // Randomized traffic against the scoreboard
        do_reset(32'h1000);
        rand_mode = 1'b1;
        repeat (3000) step();
        rand_mode = 1'b0;
        flush = 1'b0;
        id_ready = 1'b1;
        imem_req_ready = 1'b0;
        repeat (12) step();
        chk("drain_empty", exp_q.size(), 32'd0);
        chk1("random_progress", consumed > 200, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
